// File: rtl/image_fb_writer.sv
// Pairs received bytes into RGB565 pixels and writes them in raster order into a frame buffer.
// Define IMG_FB_DOUBLE_BUFFER_EN to swap write/display banks after every good frame.
module image_fb_writer #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic              img_start,
  input  logic              img_end,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_bank,
  output logic              disp_bank,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_error
);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_e;

  localparam int              PIX_N_I = IMG_W * IMG_H;
  localparam logic [ADDR_W:0] PIX_N   = PIX_N_I[ADDR_W:0];
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [7:0]      hi_q, hi_d;
  logic            over_q, over_d;
  logic            wr_en_q, wr_en_d;
  logic [ADDR_W:0] wr_addr_q, wr_addr_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            wr_bank_q, wr_bank_d;
  logic            disp_bank_q, disp_bank_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            frame_error_q, frame_error_d;
  logic            good_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hi_q          <= '0;
      over_q        <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_bank_q     <= 1'b0;
      disp_bank_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      over_q        <= over_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_bank_q     <= wr_bank_d;
      disp_bank_q   <= disp_bank_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    over_d        = over_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    frame_error_d = frame_error_q;
    good_end      = 1'b0;

    // A start always wins: it restarts the frame and drops any same-cycle byte.
    if (img_start) begin
      state_d       = WAIT_HI;
      cnt_d         = '0;
      over_d        = 1'b0;
      frame_error_d = 1'b0;
      busy_d        = 1'b1;
    end else if (state_q != IDLE) begin
      if (byte_valid) begin
        if (state_q == WAIT_HI) begin
          hi_d    = byte_in;
          state_d = WAIT_LO;
        end else begin
          state_d = WAIT_HI;
          if (cnt_q < PIX_N) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {wr_bank_q, cnt_q[ADDR_W-1:0]};
            wr_data_d = {hi_q, byte_in};
            cnt_d     = cnt_q + CNT_ONE;
          end else begin
            over_d = 1'b1;
          end
        end
      end
      // End is judged on the post-byte state so a same-cycle last byte counts.
      if (img_end) begin
        good_end      = (state_d == WAIT_HI) && (cnt_d == PIX_N) && !over_d;
        state_d       = IDLE;
        busy_d        = 1'b0;
        frame_done_d  = good_end;
        frame_error_d = !good_end;
      end
    end

`ifdef IMG_FB_DOUBLE_BUFFER_EN
    wr_bank_d   = good_end ? ~wr_bank_q : wr_bank_q;
    disp_bank_d = good_end ? wr_bank_q : disp_bank_q;
`else
    wr_bank_d   = 1'b0;
    disp_bank_d = 1'b0;
`endif
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_bank     = wr_bank_q;
  assign disp_bank   = disp_bank_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;

endmodule
